// File: rtl/conv_pkg.sv
// Constants and types shared by the row feeder and the downstream 8x8 row-convolution PE.
// Row geometry, filter width, FSM encoding and the row record carried through the output buffer.
package conv_pkg;

  localparam int PIX_W   = 2;
  localparam int ROW_PIX = 8;
  localparam int ROWS    = 8;
  localparam int TAPS    = 3;
  localparam int ROW_W   = PIX_W * ROW_PIX;
  localparam int FLT_W   = PIX_W * TAPS;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } row_t;

  // Returns row with the pixel slot at column col replaced by pix.
  function automatic logic [ROW_W-1:0] put_pix(input logic [ROW_W-1:0] row,
                                               input logic [IDX_W-1:0] col,
                                               input logic [PIX_W-1:0] pix);
    logic [ROW_W-1:0] r;
    r = row;
    r[int'(col)*PIX_W +: PIX_W] = pix;
    return r;
  endfunction

endpackage

// File: rtl/conv_row_feeder_if.sv
// Filter, pixel and row handshakes between the row feeder and its neighbours.
// master = upstream source / PE side, slave = the feeder itself.
interface conv_row_feeder_if;
  import conv_pkg::*;

  logic             flt_valid;
  logic             flt_ready;
  logic [FLT_W-1:0] flt_data;
  logic             px_valid;
  logic             px_ready;
  logic [PIX_W-1:0] px_data;
  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] row_data;
  logic [FLT_W-1:0] filter_out;
  logic [IDX_W-1:0] row_idx;
  logic             row_last;

  modport master (
    output flt_valid, flt_data, px_valid, px_data, row_ready,
    input  flt_ready, px_ready, row_valid, row_data, filter_out, row_idx, row_last
  );

  modport slave (
    input  flt_valid, flt_data, px_valid, px_data, row_ready,
    output flt_ready, px_ready, row_valid, row_data, filter_out, row_idx, row_last
  );

endinterface

// File: rtl/row_skid_buf.sv
// One-entry valid/ready holding register; zero-bubble reload when drained and refilled on the same edge.
// Latency 1 cycle; in_rdy_o = empty or being drained, content held stable while out_rdy_i is low.
module row_skid_buf
  import conv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld_i,
  input  row_t in_dat_i,
  output logic in_rdy_o,
  output logic out_vld_o,
  output row_t out_dat_o,
  input  logic out_rdy_i
);

  logic vld_q, vld_d;
  row_t dat_q, dat_d;

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld_i && in_rdy_o) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/conv_row_feeder.sv
// Packs serial 2-bit pixels into 8-pixel rows and presents them with the held filter; 1-cycle latency from 8th pixel.
// Double-buffered: one row assembles while one waits; px_ready drops only when both buffers hold rows.
module conv_row_feeder
  import conv_pkg::*;
(
  input logic clk,
  input logic rst_n,
  conv_row_feeder_if.slave bus
);

  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(ROW_PIX - 1);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);

  state_t           state_q, state_d;
  logic [FLT_W-1:0] flt_q, flt_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] asm_q, asm_d;
  logic             asm_full_q, asm_full_d;

  logic             flt_rdy, px_rdy;
  logic             flt_take, px_take, row_done;
  logic             frame_bnd;
  logic [ROW_W-1:0] asm_next;
  logic             push_vld, push_rdy, push_take;
  row_t             push_dat;
  logic             out_vld;
  row_t             out_dat;

  // A new filter may only land between frames, with nothing assembled or pending.
  assign frame_bnd = (col_q == '0) && (row_q == '0) && !asm_full_q && !out_vld;

  assign flt_take = bus.flt_valid && flt_rdy;
  assign px_take  = bus.px_valid && px_rdy;
  assign row_done = px_take && (col_q == COL_LAST);
  assign asm_next = put_pix(asm_q, col_q, bus.px_data);

  // A parked full row always has priority; it cannot coincide with row_done since px_ready is low then.
  assign push_vld      = asm_full_q || row_done;
  assign push_dat.data = asm_full_q ? asm_q : asm_next;
  assign push_dat.idx  = row_q;
  assign push_dat.last = (row_q == ROW_LAST);
  assign push_take     = push_vld && push_rdy;

  always_comb begin
    state_d    = state_q;
    flt_d      = flt_q;
    col_d      = col_q;
    row_d      = row_q;
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    flt_rdy    = 1'b0;
    px_rdy     = 1'b0;

    case (state_q)
      IDLE: begin
        flt_rdy = 1'b1;
        if (bus.flt_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        flt_rdy = frame_bnd;
        px_rdy  = !asm_full_q && !(frame_bnd && bus.flt_valid);
      end
      default: state_d = IDLE;
    endcase

    if (flt_take) begin
      flt_d = bus.flt_data;
    end

    if (px_take) begin
      asm_d = asm_next;
      col_d = col_q + 3'd1;
    end

    if (push_take) begin
      row_d = row_q + 3'd1;
    end

    if (row_done && !push_rdy) begin
      asm_full_d = 1'b1;
    end else if (asm_full_q && push_rdy) begin
      asm_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      flt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flt_q      <= flt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      asm_q      <= asm_d;
      asm_full_q <= asm_full_d;
    end
  end

  row_skid_buf u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (push_vld),
    .in_dat_i  (push_dat),
    .in_rdy_o  (push_rdy),
    .out_vld_o (out_vld),
    .out_dat_o (out_dat),
    .out_rdy_i (bus.row_ready)
  );

  assign bus.flt_ready  = flt_rdy;
  assign bus.px_ready   = px_rdy;
  assign bus.row_valid  = out_vld;
  assign bus.row_data   = out_dat.data;
  assign bus.row_idx    = out_dat.idx;
  assign bus.row_last   = out_vld && out_dat.last;
  assign bus.filter_out = flt_q;

endmodule
